// File: rtl/riscv_pkg.sv
// Shared types and defaults for the MEM/WB pipeline slice: load funct3 codes,
// writeback FSM states and datapath width defaults.
package riscv_pkg;

  localparam int XLEN_DEF = 32;
  localparam int RA_W_DEF = 5;
  localparam int TOCNT_W  = 16;

  typedef enum logic [2:0] {
    F3_LB  = 3'b000,
    F3_LH  = 3'b001,
    F3_LW  = 3'b010,
    F3_LBU = 3'b100,
    F3_LHU = 3'b101
  } load_f3_e;

  typedef enum logic {
    RUN  = 1'b0,
    WAIT = 1'b1
  } wb_state_e;

endpackage

// File: rtl/mem_wb_stage_if.sv
// EX/MEM -> WB bus: incoming instruction fields, data-memory response,
// stall back-pressure, Regfile write port and FSM debug state.
interface mem_wb_stage_if
  import riscv_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int RA_W = RA_W_DEF
);
  // Handshake: EX_MEM_valid offers an instruction; it is taken on the next
  // rising edge unless mem_stall is high, in which case upstream holds every
  // EX_MEM_* field stable. dmem_rvalid qualifies dmem_rdata for one cycle.
  logic            EX_MEM_valid;
  logic            EX_MEM_regwrite;
  logic            EX_MEM_memread;
  logic [RA_W-1:0] EX_MEM_rd;
  logic [2:0]      EX_MEM_funct3;
  logic [XLEN-1:0] EX_MEM_alures;
  logic            flush;
  logic            dmem_rvalid;
  logic [XLEN-1:0] dmem_rdata;
  logic            mem_stall;
  logic            MEM_WB_regwrite;
  logic [RA_W-1:0] MEM_WB_rd;
  logic [XLEN-1:0] WB_res;
  logic            load_err;
  wb_state_e       dbg_state;

  modport master (
    output EX_MEM_valid, EX_MEM_regwrite, EX_MEM_memread, EX_MEM_rd,
           EX_MEM_funct3, EX_MEM_alures, flush, dmem_rvalid, dmem_rdata,
    input  mem_stall, MEM_WB_regwrite, MEM_WB_rd, WB_res, load_err, dbg_state
  );

  modport slave (
    input  EX_MEM_valid, EX_MEM_regwrite, EX_MEM_memread, EX_MEM_rd,
           EX_MEM_funct3, EX_MEM_alures, flush, dmem_rvalid, dmem_rdata,
    output mem_stall, MEM_WB_regwrite, MEM_WB_rd, WB_res, load_err, dbg_state
  );

endinterface

// File: rtl/wb_load_align.sv
// Combinational load alignment: picks the byte/half/word addressed by
// addr_lo out of the raw memory word and sign- or zero-extends it.
module wb_load_align
  import riscv_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic [XLEN-1:0] i_rdata,
  input  logic [2:0]      i_funct3,
  input  logic [1:0]      i_addr_lo,
  output logic [XLEN-1:0] o_result
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = i_rdata[7:0];
    case (i_addr_lo)
      2'd0:    w_byte = i_rdata[7:0];
      2'd1:    w_byte = i_rdata[15:8];
      2'd2:    w_byte = i_rdata[23:16];
      default: w_byte = i_rdata[31:24];
    endcase
    // addr_lo[0] is deliberately ignored for halfword loads
    w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];
  end

  always_comb begin
    o_result = i_rdata;
    case (i_funct3)
      F3_LB:   o_result = {{(XLEN-8){w_byte[7]}}, w_byte};
      F3_LBU:  o_result = {{(XLEN-8){1'b0}}, w_byte};
      F3_LH:   o_result = {{(XLEN-16){w_half[15]}}, w_half};
      F3_LHU:  o_result = {{(XLEN-16){1'b0}}, w_half};
      default: o_result = i_rdata;
    endcase
  end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM->WB pipeline stage: registers ALU results and load responses onto the
// Regfile write port, stalls for late loads, times out lost ones.
// Optional retire counter output enabled by defining MEM_WB_RETIRE_CNT_EN.
module mem_wb_stage
  import riscv_pkg::*;
#(
  parameter int XLEN         = XLEN_DEF,
  parameter int RA_W         = RA_W_DEF,
  parameter int LOAD_TIMEOUT = 255
) (
  input  logic         clk,
  input  logic         rst_n,
  mem_wb_stage_if.slave bus
`ifdef MEM_WB_RETIRE_CNT_EN
  ,
  output logic [31:0]  retire_cnt
`endif
);

  localparam logic [TOCNT_W-1:0] TIMEOUT = TOCNT_W'(LOAD_TIMEOUT);

  wb_state_e           r_state;
  logic [TOCNT_W-1:0]  r_cnt;
  logic [RA_W-1:0]     r_rd_lat;
  logic [2:0]          r_f3_lat;
  logic [1:0]          r_lo_lat;
  logic                r_we_lat;
  logic                r_regwrite;
  logic [RA_W-1:0]     r_rd;
  logic [XLEN-1:0]     r_res;
  logic                r_load_err;

  logic                w_accept;
  logic                w_we_new;
  logic                w_stall;
  logic                w_wr_now;
  logic [2:0]          w_al_f3;
  logic [1:0]          w_al_lo;
  logic [XLEN-1:0]     w_aligned;

  assign w_accept = bus.EX_MEM_valid & ~bus.flush;
  assign w_we_new = bus.EX_MEM_regwrite & (bus.EX_MEM_rd != '0);

  // In WAIT the aligner must use the fields captured when the load was taken
  assign w_al_f3 = (r_state == WAIT) ? r_f3_lat : bus.EX_MEM_funct3;
  assign w_al_lo = (r_state == WAIT) ? r_lo_lat : bus.EX_MEM_alures[1:0];

  wb_load_align #(.XLEN(XLEN)) u_align (
    .i_rdata   (bus.dmem_rdata),
    .i_funct3  (w_al_f3),
    .i_addr_lo (w_al_lo),
    .o_result  (w_aligned)
  );

  always_comb begin
    w_stall  = 1'b0;
    w_wr_now = 1'b0;
    if (r_state == WAIT) begin
      w_stall  = ~bus.dmem_rvalid & (r_cnt != TIMEOUT);
      w_wr_now = bus.dmem_rvalid & r_we_lat;
    end else begin
      w_stall  = w_accept & bus.EX_MEM_memread & ~bus.dmem_rvalid;
      w_wr_now = w_accept & ~w_stall & w_we_new;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= RUN;
      r_cnt      <= '0;
      r_rd_lat   <= '0;
      r_f3_lat   <= '0;
      r_lo_lat   <= '0;
      r_we_lat   <= 1'b0;
      r_regwrite <= 1'b0;
      r_rd       <= '0;
      r_res      <= '0;
      r_load_err <= 1'b0;
    end else begin
      r_regwrite <= w_wr_now;
      case (r_state)
        RUN: begin
          r_cnt <= '0;
          if (w_accept) begin
            if (w_stall) begin
              r_rd_lat <= bus.EX_MEM_rd;
              r_f3_lat <= bus.EX_MEM_funct3;
              r_lo_lat <= bus.EX_MEM_alures[1:0];
              r_we_lat <= w_we_new;
              // the accept cycle already counts as one cycle without data
              r_cnt    <= TOCNT_W'(1);
              r_state  <= WAIT;
            end else begin
              r_rd  <= bus.EX_MEM_rd;
              r_res <= bus.EX_MEM_memread ? w_aligned : bus.EX_MEM_alures;
            end
          end
        end
        WAIT: begin
          if (bus.dmem_rvalid) begin
            r_rd    <= r_rd_lat;
            r_res   <= w_aligned;
            r_cnt   <= '0;
            r_state <= RUN;
          end else if (r_cnt == TIMEOUT) begin
            r_load_err <= 1'b1;
            r_cnt      <= '0;
            r_state    <= RUN;
          end else begin
            r_cnt <= r_cnt + TOCNT_W'(1);
          end
        end
        default: r_state <= RUN;
      endcase
    end
  end

  assign bus.mem_stall       = w_stall;
  assign bus.MEM_WB_regwrite = r_regwrite;
  assign bus.MEM_WB_rd       = r_rd;
  assign bus.WB_res          = r_res;
  assign bus.load_err        = r_load_err;
  assign bus.dbg_state       = r_state;

`ifdef MEM_WB_RETIRE_CNT_EN
  logic [31:0] r_retire_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_retire_cnt <= '0;
    end else if (w_wr_now) begin
      r_retire_cnt <= r_retire_cnt + 32'd1;
    end
  end

  assign retire_cnt = r_retire_cnt;
`endif

endmodule

// File: tb/tb_mem_wb_stage.sv
// Bench for mem_wb_stage: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against a transaction-level model.
module tb_mem_wb_stage;
  import riscv_pkg::*;

  localparam int XLEN = 32;
  localparam int RA_W = 5;
  localparam int TO   = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mem_wb_stage_if #(.XLEN(XLEN), .RA_W(RA_W)) bus ();

`ifdef MEM_WB_RETIRE_CNT_EN
  logic [31:0] retire_cnt;
  logic [31:0] cnt_off = '0;
`endif

  mem_wb_stage #(.XLEN(XLEN), .RA_W(RA_W), .LOAD_TIMEOUT(TO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef MEM_WB_RETIRE_CNT_EN
    ,
    .retire_cnt (retire_cnt)
`endif
  );

  int errors = 0;
  int checks = 0;
  logic [XLEN-1:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  bit              m_pend   = 1'b0;
  int              m_waited = 0;
  logic [RA_W-1:0] m_rd     = '0;
  logic [2:0]      m_f3     = '0;
  logic [1:0]      m_lo     = '0;
  bit              m_we     = 1'b0;
  bit              e_we     = 1'b0;
  logic [RA_W-1:0] e_rd     = '0;
  logic [XLEN-1:0] e_res    = '0;
  bit              e_err    = 1'b0;
  logic [31:0]     e_cnt    = '0;

  function automatic logic [31:0] model_load(input logic [31:0] w, input logic [2:0] f3,
                                             input logic [1:0] lo);
    logic [31:0] b;
    logic [31:0] h;
    b = w >> (8 * lo);
    h = w >> (16 * lo[1]);
    case (f3)
      3'b000:  return 32'($signed(b[7:0]));
      3'b100:  return {24'h0, b[7:0]};
      3'b001:  return 32'($signed(h[15:0]));
      3'b101:  return {16'h0, h[15:0]};
      default: return w;
    endcase
  endfunction

  function automatic bit model_we();
    return bus.EX_MEM_regwrite && (bus.EX_MEM_rd != 0);
  endfunction

  function automatic logic [31:0] model_res();
    if (bus.EX_MEM_memread)
      return model_load(bus.dmem_rdata, bus.EX_MEM_funct3, bus.EX_MEM_alures[1:0]);
    return bus.EX_MEM_alures;
  endfunction

  // Stalled cycles = accept cycle plus WAIT cycles, capped at TO in total
  function automatic bit model_stall();
    if (m_pend) return !bus.dmem_rvalid && (m_waited != TO);
    return bus.EX_MEM_valid && !bus.flush && bus.EX_MEM_memread && !bus.dmem_rvalid;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pend <= 1'b0; m_waited <= 0; e_we <= 1'b0; e_rd <= '0;
      e_res <= '0; e_err <= 1'b0; e_cnt <= '0;
      exp_q.delete();
    end else if (m_pend) begin
      if (bus.dmem_rvalid) begin
        m_pend <= 1'b0;
        e_we   <= m_we;
        e_rd   <= m_rd;
        e_res  <= model_load(bus.dmem_rdata, m_f3, m_lo);
        if (m_we) begin
          exp_q.push_back(model_load(bus.dmem_rdata, m_f3, m_lo));
          e_cnt <= e_cnt + 32'd1;
        end
      end else if (m_waited == TO) begin
        m_pend <= 1'b0;
        e_we   <= 1'b0;
        e_err  <= 1'b1;
      end else begin
        e_we     <= 1'b0;
        m_waited <= m_waited + 1;
      end
    end else if (bus.EX_MEM_valid && !bus.flush) begin
      if (bus.EX_MEM_memread && !bus.dmem_rvalid) begin
        m_pend   <= 1'b1;
        m_waited <= 1;
        m_rd     <= bus.EX_MEM_rd;
        m_f3     <= bus.EX_MEM_funct3;
        m_lo     <= bus.EX_MEM_alures[1:0];
        m_we     <= model_we();
        e_we     <= 1'b0;
      end else begin
        e_we  <= model_we();
        e_rd  <= bus.EX_MEM_rd;
        e_res <= model_res();
        if (model_we()) begin
          exp_q.push_back(model_res());
          e_cnt <= e_cnt + 32'd1;
        end
      end
    end else begin
      e_we <= 1'b0;
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (rst_n) begin
      check("mem_stall", 64'(bus.mem_stall), 64'(model_stall()));
      check("regwrite", 64'(bus.MEM_WB_regwrite), 64'(e_we));
      check("wb_rd", 64'(bus.MEM_WB_rd), 64'(e_rd));
      check("wb_res", 64'(bus.WB_res), 64'(e_res));
      check("load_err", 64'(bus.load_err), 64'(e_err));
      check("state_wait", 64'(bus.dbg_state == WAIT), 64'(m_pend));
      if (bus.MEM_WB_regwrite) begin
        if (exp_q.size() == 0) begin
          check("write_unexpected", 64'(1), 64'(0));
        end else begin
          check("write_data", 64'(bus.WB_res), 64'(exp_q.pop_front()));
        end
      end
`ifdef MEM_WB_RETIRE_CNT_EN
      check("retire_cnt", 64'(retire_cnt), 64'(e_cnt + cnt_off));
`endif
    end
  end

  // ---------------- driver ----------------
  task automatic drive(input bit v, input bit rw, input bit mr, input logic [RA_W-1:0] rd,
                       input logic [2:0] f3, input logic [XLEN-1:0] alu, input bit fl,
                       input bit rv, input logic [XLEN-1:0] rdata);
    bus.EX_MEM_valid    = v;
    bus.EX_MEM_regwrite = rw;
    bus.EX_MEM_memread  = mr;
    bus.EX_MEM_rd       = rd;
    bus.EX_MEM_funct3   = f3;
    bus.EX_MEM_alures   = alu;
    bus.flush           = fl;
    bus.dmem_rvalid     = rv;
    bus.dmem_rdata      = rdata;
  endtask

  task automatic idle();
    drive(0, 0, 0, '0, '0, '0, 0, 0, '0);
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, required finish before 1ms");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    idle();
    repeat (2) @(posedge clk);
    #2;
    check("reset_regwrite", 64'(bus.MEM_WB_regwrite), 64'(0));
    check("reset_res", 64'(bus.WB_res), 64'(0));
    check("reset_err", 64'(bus.load_err), 64'(0));
    check("reset_state", 64'(bus.dbg_state), 64'(RUN));
    rst_n = 1'b1;
    tick();

    // 1: plain ALU result
    drive(1, 1, 0, 5'd5, 3'b000, 32'h1234_5678, 0, 0, '0);
    #1 check("t1_stall", 64'(bus.mem_stall), 64'(0));
    tick();
    check("t1_we", 64'(bus.MEM_WB_regwrite), 64'(1));
    check("t1_rd", 64'(bus.MEM_WB_rd), 64'(5));
    check("t1_res", 64'(bus.WB_res), 64'h1234_5678);

    // 2: same-cycle byte loads at addr_lo=3
    drive(1, 1, 1, 5'd6, 3'b000, 32'h0000_1003, 0, 1, 32'h80AA_BBCC);
    tick();
    check("t2_lb", 64'(bus.WB_res), 64'hFFFF_FF80);
    drive(1, 1, 1, 5'd6, 3'b100, 32'h0000_1003, 0, 1, 32'h80AA_BBCC);
    tick();
    check("t2_lbu", 64'(bus.WB_res), 64'h0000_0080);
    check("t2_we", 64'(bus.MEM_WB_regwrite), 64'(1));

    // 3: LHU with response 3 cycles late
    drive(1, 1, 1, 5'd8, 3'b101, 32'h0000_2002, 0, 0, '0);
    for (int i = 0; i < 3; i++) begin
      #1 check("t3_stall", 64'(bus.mem_stall), 64'(1));
      tick();
      check("t3_bubble", 64'(bus.MEM_WB_regwrite), 64'(0));
    end
    bus.dmem_rvalid = 1'b1;
    bus.dmem_rdata  = 32'hBEEF_0001;
    #1 check("t3_stall_drop", 64'(bus.mem_stall), 64'(0));
    tick();
    check("t3_res", 64'(bus.WB_res), 64'h0000_BEEF);
    check("t3_we", 64'(bus.MEM_WB_regwrite), 64'(1));
    check("t3_rd", 64'(bus.MEM_WB_rd), 64'(8));

    // 4: lost response times out after TO stalled cycles
    drive(1, 1, 1, 5'd9, 3'b010, 32'h0000_3000, 0, 0, '0);
    for (int i = 0; i < TO; i++) begin
      #1 check("t4_stall", 64'(bus.mem_stall), 64'(1));
      tick();
    end
    #1 check("t4_stall_drop", 64'(bus.mem_stall), 64'(0));
    tick();
    check("t4_err", 64'(bus.load_err), 64'(1));
    check("t4_nowrite", 64'(bus.MEM_WB_regwrite), 64'(0));
    drive(1, 1, 0, 5'd7, 3'b000, 32'h0000_CAFE, 0, 0, '0);
    tick();
    check("t4_alu_after", 64'(bus.MEM_WB_regwrite), 64'(1));
    check("t4_alu_res", 64'(bus.WB_res), 64'h0000_CAFE);

    // 5: rd=0, flushed op, flush during WAIT
    drive(1, 1, 0, 5'd0, 3'b000, 32'h0000_0011, 0, 0, '0);
    tick();
    check("t5_rd0", 64'(bus.MEM_WB_regwrite), 64'(0));
    drive(1, 1, 0, 5'd3, 3'b000, 32'h0000_0022, 1, 0, '0);
    tick();
    check("t5_flush", 64'(bus.MEM_WB_regwrite), 64'(0));
    check("t5_flush_hold", 64'(bus.WB_res), 64'h0000_0011);
    drive(1, 1, 1, 5'd9, 3'b010, 32'h0000_4000, 0, 0, '0);
    tick();
    bus.flush = 1'b1;
    tick();
    bus.dmem_rvalid = 1'b1;
    bus.dmem_rdata  = 32'h1122_3344;
    tick();
    check("t5_wait_flush_we", 64'(bus.MEM_WB_regwrite), 64'(1));
    check("t5_wait_flush_res", 64'(bus.WB_res), 64'h1122_3344);
    idle();
    tick();

    // randomized traffic; upstream holds EX/MEM while stalled
    begin
      bit held = 1'b0;
      for (int n = 0; n < 600; n++) begin
        if (!held) begin
          bus.EX_MEM_valid    = ($urandom_range(0, 3) != 0);
          bus.EX_MEM_regwrite = ($urandom_range(0, 4) != 0);
          bus.EX_MEM_memread  = $urandom_range(0, 1);
          bus.EX_MEM_rd       = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
          bus.EX_MEM_funct3   = 3'($urandom_range(0, 7));
          bus.EX_MEM_alures   = $urandom;
        end
        bus.flush       = ($urandom_range(0, 5) == 0);
        bus.dmem_rvalid = ($urandom_range(0, 4) < 2);
        bus.dmem_rdata  = $urandom;
        #1 held = model_stall();
        tick();
      end
    end
    drive(0, 0, 0, '0, '0, '0, 0, 1, '0);
    tick();
    idle();
    tick();

    // 6: async reset in the middle of WAIT
    drive(1, 1, 1, 5'd12, 3'b010, 32'h0000_5000, 0, 0, '0);
    tick();
    rst_n = 1'b0;
    #1;
    check("t6_we", 64'(bus.MEM_WB_regwrite), 64'(0));
    check("t6_rd", 64'(bus.MEM_WB_rd), 64'(0));
    check("t6_res", 64'(bus.WB_res), 64'(0));
    check("t6_err", 64'(bus.load_err), 64'(0));
    check("t6_state", 64'(bus.dbg_state), 64'(RUN));
    drive(0, 0, 0, '0, '0, '0, 0, 1, 32'hDEAD_BEEF);
    tick();
    rst_n = 1'b1;
    tick();
    check("t6_late_rvalid", 64'(bus.MEM_WB_regwrite), 64'(0));
    check("t6_late_res", 64'(bus.WB_res), 64'(0));
    idle();
    tick();

`ifdef MEM_WB_RETIRE_CNT_EN
    force dut.r_retire_cnt = 32'hFFFF_FFFF;
    cnt_off = 32'hFFFF_FFFF - e_cnt;
    #1 release dut.r_retire_cnt;
    drive(1, 1, 0, 5'd4, 3'b000, 32'h0000_0044, 0, 0, '0);
    tick();
    check("retire_wrap", 64'(retire_cnt), 64'(0));
    tick();
    check("retire_after_wrap", 64'(retire_cnt), 64'(1));
    idle();
    tick();
`endif

    check("scoreboard_empty", 64'(exp_q.size()), 64'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
